payload_byte_serializer: RTL and testbench
==========================================

Name: payload_byte_serializer

Overview:
- Read-side consumer of pre_data_buffer, running in the eth_clk domain.
- Pops one frame of data_points words when the buffer is non-empty and latches it.
- Streams the frame MSB-first as bytes on an AXI-Stream-style 8-bit master interface into the UDP packetizer payload path.
- Marks the last byte of each frame with m_tlast.

Parameters:
- N, 8: word MSB index; each word is N+1 bits wide.
- data_points, 5: words per frame.
- BPW, (N+8)/8 (derived localparam, not overridable): bytes per word = ceil((N+1)/8).

Ports:
- eth_clk  in  1  sole clock, all logic rising-edge.
- sclr_n  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- data_in  in  data_points*(N+1)  frame from buffer data_out, word 0 in most-significant slice.
- empty  in  1  buffer empty flag.
- rvalid  in  1  buffer read-data-valid.
- rready  out  1  pop request to buffer.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  byte valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  last byte of frame.
- busy  out  1  high in any state except IDLE.
- frame_count  out  16  frames fully sent, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (sclr_n=0, any time, including mid-frame):
  - State goes to IDLE immediately.
  - rready, m_tvalid, m_tlast, busy are 0; m_tdata is 0x00; frame_count is 0; byte index is 0.
  - A partial frame is discarded; no tlast is emitted for it.
- FSM states: IDLE, REQ, WAIT, SEND (HDR when feature enabled).
- IDLE:
  - empty=1: remain in IDLE.
  - empty=0: go to REQ.
- REQ: rready=1 for exactly one cycle, then go to WAIT. rready is 0 in every other state.
- WAIT:
  - On the first cycle with rvalid=1, latch data_in into the frame register and go to SEND (or HDR).
  - rvalid arriving in the same cycle as REQ is ignored; the buffer is required to respond no earlier than the cycle after rready.
  - No timeout; WAIT holds indefinitely.
- SEND: byte k = 0..data_points*BPW-1 is taken as follows.
  - Word w = k/BPW.
  - Byte b = k%BPW within the word, b=0 being most significant.
  - The word is zero-extended to BPW*8 bits; padding bits are always 0.
- Latency: first byte has m_tvalid=1 on the cycle after rvalid is sampled in WAIT. From IDLE with empty=0 and immediate rvalid, the first byte appears 3 cycles after IDLE exit.
- Stream rules:
  - A byte transfers on a cycle with m_tvalid=1 and m_tready=1.
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
  - m_tvalid never drops without a transfer except on reset.
  - With m_tready held at 1, one byte transfers per cycle, no bubbles.
- m_tlast=1 only on byte data_points*BPW-1.
- On transfer of the tlast byte:
  - frame_count increments in the same cycle.
  - m_tvalid drops the next cycle.
  - FSM returns to IDLE; the next frame is not requested until IDLE is re-entered, giving at least 1 idle cycle between frames.
- empty or rvalid changing during SEND is ignored.
- Frame register is loaded only in WAIT.

Optional Feature:
- Macro: PAYLOAD_SEQ_HEADER_EN.
- Defined:
  - HDR state inserted between WAIT and SEND.
  - Emits 2 bytes: frame_count[15:8], then frame_count[7:0], using the value before this frame's increment.
  - Same stream rules as SEND.
  - Frame length is 2+data_points*BPW bytes; tlast stays on the final data byte.
- Undefined: HDR state absent; frame is data bytes only.

Test Plan:
- Reset then buffer non-empty, N=8, data_points=5, data_in = {0x0C0,0x1FF,0x0EE,0x00F,0x0F0}, rvalid the cycle after rready, m_tready=1 -> single rready pulse; 10 consecutive bytes 00 C0 01 FF 00 EE 00 0F 00 F0; tlast only on F0; frame_count=1.
- Same frame with m_tready toggled 1,0,0,1 repeating -> identical byte sequence; data and tlast stable during every stall; no dropped or duplicated bytes.
- empty=1 for 50 cycles -> rready never asserted, busy=0, m_tvalid=0.
- rvalid delayed 7 cycles after rready -> stays in WAIT with busy=1; first byte valid the cycle after rvalid.
- sclr_n pulsed low after byte 4 of a frame -> all outputs at reset values asynchronously; next frame restarts at byte 0; frame_count=0.
- PAYLOAD_SEQ_HEADER_EN defined, two back-to-back frames -> frame 1 begins 00 00, frame 2 begins 00 01; each frame is 12 bytes; frame_count=2.

Source files
------------

// File: rtl/payload_byte_serializer_if.sv
// Byte-wide AXI-Stream-style link from the payload serializer into the UDP packetizer.
interface payload_byte_serializer_if;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/payload_byte_serializer.sv
// Pops one frame from pre_data_buffer and streams it MSB-first as bytes, tlast on the final byte.
// Optional macro PAYLOAD_SEQ_HEADER_EN prepends a 2-byte frame_count header to every frame.
module payload_byte_serializer #(
  parameter int N           = 8,
  parameter int data_points = 5
) (
  input  logic                          eth_clk,
  input  logic                          sclr_n,
  input  logic [data_points*(N+1)-1:0]  data_in,
  input  logic                          empty,
  input  logic                          rvalid,
  output logic                          rready,
  payload_byte_serializer_if.master     m,
  output logic                          busy,
  output logic [15:0]                   frame_count
);

  localparam int BPW  = (N + 8) / 8;
  localparam int WW   = N + 1;
  localparam int FW   = data_points * WW;
  localparam int NB   = data_points * BPW;
  localparam int LAST = NB - 1;
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;

`ifdef PAYLOAD_SEQ_HEADER_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HDR,
    S_SEND
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND
  } state_t;
`endif

  state_t          r_state;
  logic            r_rready;
  logic [7:0]      r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic [15:0]     r_frame_count;
  logic [FW-1:0]   r_frame;
  logic [IW-1:0]   r_idx;
`ifdef PAYLOAD_SEQ_HEADER_EN
  logic            r_hidx;
`endif

  // In WAIT the frame register is not loaded yet, so byte 0 must come straight from data_in.
  logic [FW-1:0]   w_src;
  logic [BPW*8-1:0] w_word_ext [0:data_points-1];
  logic [7:0]      w_byte [0:NB-1];
  logic [IW-1:0]   w_idx_next;
  logic [7:0]      w_next_byte;

  assign w_src = (r_state == S_WAIT) ? data_in : r_frame;

  for (genvar gi = 0; gi < data_points; gi++) begin : g_word
    assign w_word_ext[gi] = (BPW*8)'(w_src[FW-1-gi*WW -: WW]);
    for (genvar gj = 0; gj < BPW; gj++) begin : g_byte
      assign w_byte[gi*BPW+gj] = w_word_ext[gi][(BPW-gj)*8-1 -: 8];
    end
  end

  assign w_idx_next  = r_idx + 1'b1;
  assign w_next_byte = (r_idx == IW'(LAST)) ? 8'h00 : w_byte[w_idx_next];

  always_ff @(posedge eth_clk or negedge sclr_n) begin
    if (!sclr_n) begin
      r_state       <= S_IDLE;
      r_rready      <= 1'b0;
      r_tdata       <= 8'h00;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_frame_count <= 16'h0000;
      r_frame       <= '0;
      r_idx         <= '0;
`ifdef PAYLOAD_SEQ_HEADER_EN
      r_hidx        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!empty) begin
            r_state  <= S_REQ;
            r_rready <= 1'b1;
          end
        end
        S_REQ: begin
          r_rready <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (rvalid) begin
            r_frame  <= data_in;
            r_tvalid <= 1'b1;
`ifdef PAYLOAD_SEQ_HEADER_EN
            r_tdata  <= r_frame_count[15:8];
            r_tlast  <= 1'b0;
            r_hidx   <= 1'b0;
            r_state  <= S_HDR;
`else
            r_tdata  <= w_byte[0];
            r_tlast  <= (LAST == 0);
            r_idx    <= '0;
            r_state  <= S_SEND;
`endif
          end
        end
`ifdef PAYLOAD_SEQ_HEADER_EN
        S_HDR: begin
          if (m.m_tready) begin
            if (!r_hidx) begin
              r_tdata <= r_frame_count[7:0];
              r_hidx  <= 1'b1;
            end else begin
              r_tdata <= w_byte[0];
              r_tlast <= (LAST == 0);
              r_idx   <= '0;
              r_state <= S_SEND;
            end
          end
        end
`endif
        S_SEND: begin
          // tvalid is always high here, so tready alone marks a transfer.
          if (m.m_tready) begin
            if (r_tlast) begin
              r_frame_count <= r_frame_count + 16'h0001;
              r_tvalid      <= 1'b0;
              r_tlast       <= 1'b0;
              r_tdata       <= 8'h00;
              r_idx         <= '0;
              r_state       <= S_IDLE;
            end else begin
              r_idx   <= w_idx_next;
              r_tdata <= w_next_byte;
              r_tlast <= (w_idx_next == IW'(LAST));
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rready      = r_rready;
  assign m.m_tdata   = r_tdata;
  assign m.m_tvalid  = r_tvalid;
  assign m.m_tlast   = r_tlast;
  assign busy        = (r_state != S_IDLE);
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_payload_byte_serializer.sv
// Directed bench for payload_byte_serializer: frames, stalls, delayed rvalid, mid-frame reset.
module tb_payload_byte_serializer;
  localparam int N  = 8;
  localparam int DP = 5;

  logic                 eth_clk = 1'b0;
  logic                 sclr_n  = 1'b0;
  logic [DP*(N+1)-1:0]  data_in = {9'h0C0, 9'h1FF, 9'h0EE, 9'h00F, 9'h0F0};
  logic                 empty   = 1'b1;
  logic                 rvalid  = 1'b0;
  logic                 rready;
  logic                 busy;
  logic [15:0]          frame_count;

  payload_byte_serializer_if m ();

  int errors = 0;
  int checks = 0;

  logic [7:0] data_bytes [0:9] = '{8'h00, 8'hC0, 8'h01, 8'hFF, 8'h00,
                                   8'hEE, 8'h00, 8'h0F, 8'h00, 8'hF0};
  logic [7:0] exp_bytes [0:11];
  int         exp_len;

  always #5 eth_clk = ~eth_clk;

  payload_byte_serializer #(.N(N), .data_points(DP)) dut (
    .eth_clk     (eth_clk),
    .sclr_n      (sclr_n),
    .data_in     (data_in),
    .empty       (empty),
    .rvalid      (rvalid),
    .rready      (rready),
    .m           (m),
    .busy        (busy),
    .frame_count (frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [15:0] fc);
    int k;
    k = 0;
`ifdef PAYLOAD_SEQ_HEADER_EN
    exp_bytes[0] = fc[15:8];
    exp_bytes[1] = fc[7:0];
    k = 2;
`endif
    for (int i = 0; i < 10; i++) exp_bytes[k+i] = data_bytes[i];
    exp_len = k + 10;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_tvalid"}, m.m_tvalid, 0);
    chk({tag, "_tlast"},  m.m_tlast, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_tdata"},  m.m_tdata, 8'h00);
    chk({tag, "_fcount"}, frame_count, 16'h0000);
  endtask

  task automatic do_frame(input int rv_delay, input bit stall, input bit hold_empty,
                          input int abort_at, input logic [15:0] exp_fc);
    int cyc;
    int nb;
    int rr_cnt;
    int ph;
    bit pend;
    logic [7:0] hd;
    logic hl;
    cyc = 0; nb = 0; ph = 0; pend = 0; hd = 8'h00; hl = 1'b0;
    empty = 1'b0;
    m.m_tready = 1'b0;
    @(negedge eth_clk);
    while (rready !== 1'b1 && cyc < 100) begin
      @(negedge eth_clk);
      cyc++;
    end
    chk("rready_seen", rready, 1);
    rr_cnt = 1;
    @(negedge eth_clk);
    for (int i = 0; i < rv_delay; i++) begin
      rr_cnt += int'(rready);
      chk("wait_busy_novalid", {busy, m.m_tvalid}, 2'b10);
      @(negedge eth_clk);
    end
    rr_cnt += int'(rready);
    rvalid = 1'b1;
    if (!hold_empty) empty = 1'b1;
    @(negedge eth_clk);
    rvalid = 1'b0;
    chk("first_valid", m.m_tvalid, 1);
    while (nb < exp_len && cyc < 400) begin
      if (abort_at > 0 && nb == abort_at) return;
      m.m_tready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      rr_cnt += int'(rready);
      chk("tvalid_held", m.m_tvalid, 1);
      if (pend) begin
        chk("stall_data", m.m_tdata, hd);
        chk("stall_last", m.m_tlast, hl);
      end
      if (m.m_tready) begin
        chk($sformatf("byte%0d", nb), m.m_tdata, exp_bytes[nb]);
        chk($sformatf("tlast%0d", nb), m.m_tlast, nb == exp_len - 1);
        nb++;
        pend = 0;
      end else begin
        pend = 1;
        hd = m.m_tdata;
        hl = m.m_tlast;
      end
      @(negedge eth_clk);
      cyc++;
    end
    chk("byte_count", nb, exp_len);
    chk("tvalid_drop", m.m_tvalid, 0);
    chk("idle_after", busy, 0);
    chk("rready_pulses", rr_cnt, 1);
    chk("frame_count", frame_count, exp_fc);
    $display("frame done: bytes=%0d frame_count=%0d", nb, frame_count);
  endtask

  initial begin
    int bad;
    m.m_tready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge eth_clk);
    sclr_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge eth_clk);
      if (rready || busy || m.m_tvalid) bad++;
    end
    chk("idle_quiet", bad, 0);
    $display("idle: 50 cycles empty, violations=%0d", bad);

    set_exp(16'd0); do_frame(0, 1'b0, 1'b0, 0, 16'd1);
    set_exp(16'd1); do_frame(0, 1'b1, 1'b0, 0, 16'd2);
    set_exp(16'd2); do_frame(6, 1'b0, 1'b0, 0, 16'd3);

    set_exp(16'd3); do_frame(0, 1'b0, 1'b0, 4, 16'd0);
    chk("pre_reset_valid", m.m_tvalid, 1);
    sclr_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    $display("mid-frame reset applied, frame_count=%0d", frame_count);
    @(negedge eth_clk);
    sclr_n = 1'b1;
    empty = 1'b1;

    set_exp(16'd0); do_frame(0, 1'b0, 1'b1, 0, 16'd1);
    set_exp(16'd1); do_frame(0, 1'b0, 1'b0, 0, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
